// File: rtl/apb_ram_strb.sv
// -----------------------------------------------------------------------------
// apb_ram_strb
//   APB4 slave RAM with byte-lane write strobes, a programmable wait-state
//   counter, an out-of-range error response and protocol-abort handling.
//
//   Optional build macro: APB_RAM_RO_REGION_EN
//     When defined, words RO_BASE..RAM_DEPTH-1 are read-only. Writes there
//     complete with pslverr=1 and leave memory untouched.
//
// Ports
//   pclk     in   rising-edge clock
//   presetn  in   synchronous reset, ACTIVE-HIGH (1 = reset) despite its name
//   psel     in   slave select
//   penable  in   access-phase qualifier
//   pwrite   in   1 = write, 0 = read
//   paddr    in   byte address [ADDR_WIDTH]
//   pwdata   in   write data [DATA_WIDTH]
//   pstrb    in   byte write strobes [DATA_WIDTH/8]
//   prdata   out  read data, held until the next read commit
//   pready   out  transfer complete, high for exactly one cycle
//   pslverr  out  error response, only ever high together with pready
// -----------------------------------------------------------------------------
module apb_ram_strb #(
  parameter int unsigned ADDR_WIDTH  = 8,
  parameter int unsigned DATA_WIDTH  = 32,
  parameter int unsigned RAM_DEPTH   = 64,
  parameter int unsigned WAIT_CYCLES = 0,
  parameter int unsigned RO_BASE     = 48
) (
  input  logic                      pclk,
  input  logic                      presetn,
  input  logic                      psel,
  input  logic                      penable,
  input  logic                      pwrite,
  input  logic [ADDR_WIDTH-1:0]     paddr,
  input  logic [DATA_WIDTH-1:0]     pwdata,
  input  logic [DATA_WIDTH/8-1:0]   pstrb,
  output logic [DATA_WIDTH-1:0]     prdata,
  output logic                      pready,
  output logic                      pslverr
);

  localparam int unsigned NBYTES = DATA_WIDTH / 8;
  localparam int unsigned LSB    = (NBYTES > 1) ? $clog2(NBYTES) : 0;
  localparam int unsigned IDX_W  = ADDR_WIDTH - LSB;
  localparam int unsigned MEM_AW = (RAM_DEPTH > 1) ? $clog2(RAM_DEPTH) : 1;

  // ---------------------------------------------------------------------------
  // Elaboration-time parameter checks
  // ---------------------------------------------------------------------------
  generate
    if ((DATA_WIDTH % 8) != 0 || DATA_WIDTH < 8) begin : g_bad_dw
      $error("apb_ram_strb: DATA_WIDTH must be a multiple of 8, minimum 8");
    end
    if (WAIT_CYCLES > 15) begin : g_bad_wait
      $error("apb_ram_strb: WAIT_CYCLES must be in 0..15");
    end
    if (ADDR_WIDTH <= LSB || ADDR_WIDTH > 32) begin : g_bad_aw
      $error("apb_ram_strb: ADDR_WIDTH must exceed the byte-lane bits and be <= 32");
    end
  endgenerate

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ACCESS = 2'd1,
    ST_RESP   = 2'd2
  } state_t;

  state_t                  state_reg, state_next;
  logic [3:0]              cnt_reg, cnt_next;
  logic [IDX_W-1:0]        idx_reg, idx_next;
  logic                    write_reg, write_next;
  logic [DATA_WIDTH-1:0]   wdata_reg, wdata_next;
  logic [NBYTES-1:0]       strb_reg, strb_next;
  logic [DATA_WIDTH-1:0]   prdata_reg, prdata_next;
  logic                    pready_reg, pready_next;
  logic                    pslverr_reg, pslverr_next;

  logic                    mem_we;
  logic [MEM_AW-1:0]       mem_addr;
  logic [DATA_WIDTH-1:0]   rd_word;
  logic                    in_range;
  logic                    ro_hit;

  // Low address bits only select a byte inside the word and are ignored.
  generate
    if (LSB > 0) begin : g_lsb_unused
      logic unused_lsb;
      assign unused_lsb = ^paddr[LSB-1:0];
    end
  endgenerate

  // Comparisons done at 32 bits so any IDX_W / RAM_DEPTH combination works.
  assign in_range = (32'(idx_reg) < RAM_DEPTH);
  assign mem_addr = MEM_AW'(idx_reg);

`ifdef APB_RAM_RO_REGION_EN
  generate
    if (RO_BASE > RAM_DEPTH) begin : g_bad_ro
      $error("apb_ram_strb: RO_BASE must be <= RAM_DEPTH");
    end
  endgenerate
  assign ro_hit = write_reg && (32'(idx_reg) >= RO_BASE);
`else
  logic unused_ro_base;
  assign unused_ro_base = (RO_BASE != 0);
  assign ro_hit         = 1'b0;
`endif

  // ---------------------------------------------------------------------------
  // Storage: one byte-wide array per lane, so strobes map to per-lane write
  // enables. A write committing on the same edge as reset is suppressed.
  // ---------------------------------------------------------------------------
  generate
    for (genvar gi = 0; gi < NBYTES; gi++) begin : g_lane
      logic [7:0] lane_mem [RAM_DEPTH];

      always_ff @(posedge pclk) begin
        if (mem_we && !presetn && strb_reg[gi]) begin
          lane_mem[mem_addr] <= wdata_reg[8*gi +: 8];
        end
      end

      assign rd_word[8*gi +: 8] = lane_mem[mem_addr];
    end
  endgenerate

  // ---------------------------------------------------------------------------
  // Next-state / output logic
  // ---------------------------------------------------------------------------
  always_comb begin
    state_next   = state_reg;
    cnt_next     = cnt_reg;
    idx_next     = idx_reg;
    write_next   = write_reg;
    wdata_next   = wdata_reg;
    strb_next    = strb_reg;
    prdata_next  = prdata_reg;
    pready_next  = 1'b0;
    pslverr_next = 1'b0;
    mem_we       = 1'b0;

    unique case (state_reg)
      ST_IDLE: begin
        if (psel && !penable) begin
          idx_next   = paddr[ADDR_WIDTH-1:LSB];
          write_next = pwrite;
          wdata_next = pwdata;
          strb_next  = pstrb;
          cnt_next   = 4'(WAIT_CYCLES);
          state_next = ST_ACCESS;
        end
      end

      ST_ACCESS: begin
        if (!psel || !penable) begin
          // Master abandoned the transfer: nothing is committed.
          state_next = ST_IDLE;
        end else if (cnt_reg != 4'd0) begin
          cnt_next = cnt_reg - 4'd1;
        end else begin
          state_next  = ST_RESP;
          pready_next = 1'b1;
          if (!in_range) begin
            pslverr_next = 1'b1;
            prdata_next  = '0;
          end else if (write_reg) begin
            if (ro_hit) begin
              pslverr_next = 1'b1;
            end else begin
              mem_we = 1'b1;
            end
          end else begin
            prdata_next = rd_word;
          end
        end
      end

      ST_RESP: begin
        // Bus is ignored here; the master samples pready this cycle.
        state_next = ST_IDLE;
      end

      default: begin
        state_next = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge pclk) begin
    if (presetn) begin
      state_reg   <= ST_IDLE;
      cnt_reg     <= 4'd0;
      idx_reg     <= '0;
      write_reg   <= 1'b0;
      wdata_reg   <= '0;
      strb_reg    <= '0;
      prdata_reg  <= '0;
      pready_reg  <= 1'b0;
      pslverr_reg <= 1'b0;
    end else begin
      state_reg   <= state_next;
      cnt_reg     <= cnt_next;
      idx_reg     <= idx_next;
      write_reg   <= write_next;
      wdata_reg   <= wdata_next;
      strb_reg    <= strb_next;
      prdata_reg  <= prdata_next;
      pready_reg  <= pready_next;
      pslverr_reg <= pslverr_next;
    end
  end

  assign prdata  = prdata_reg;
  assign pready  = pready_reg;
  assign pslverr = pslverr_reg;

endmodule

// File: tb/tb_apb_ram_strb.sv
// -----------------------------------------------------------------------------
// tb_apb_ram_strb
//   Scoreboard bench for apb_ram_strb. The stimulus tasks compute the expected
//   response from a word/byte-level memory model and queue it; an independent
//   monitor pops and checks on every pready, including the access-phase
//   latency seen on the bus.
// -----------------------------------------------------------------------------
module tb_apb_ram_strb;

  localparam int AW      = 9;
  localparam int DW      = 32;
  localparam int NB      = DW / 8;
  localparam int DEPTH   = 64;
  localparam int WAITC   = 3;
  localparam int RO_BASE = 48;
  localparam int LAT     = WAITC + 2;

  logic          pclk = 1'b0;
  logic          presetn;
  logic          psel;
  logic          penable;
  logic          pwrite;
  logic [AW-1:0] paddr;
  logic [DW-1:0] pwdata;
  logic [NB-1:0] pstrb;
  logic [DW-1:0] prdata;
  logic          pready;
  logic          pslverr;

  always #5 pclk = ~pclk;

  apb_ram_strb #(
    .ADDR_WIDTH (AW),
    .DATA_WIDTH (DW),
    .RAM_DEPTH  (DEPTH),
    .WAIT_CYCLES(WAITC),
    .RO_BASE    (RO_BASE)
  ) dut (
    .pclk   (pclk),
    .presetn(presetn),
    .psel   (psel),
    .penable(penable),
    .pwrite (pwrite),
    .paddr  (paddr),
    .pwdata (pwdata),
    .pstrb  (pstrb),
    .prdata (prdata),
    .pready (pready),
    .pslverr(pslverr)
  );

  typedef struct {
    bit            is_read;
    logic [AW-1:0] addr;
    logic [31:0]   data;
    logic [31:0]   mask;   // bytes of data that are defined
    bit            err;
  } exp_t;

  exp_t exp_q[$];
  exp_t mon_e;

  logic [31:0] ref_mem   [DEPTH];
  bit   [3:0]  ref_known [DEPTH];

  int n_vec  = 0;
  int n_bad  = 0;
  int acc_cnt = 0;

  // Reference model: a word array plus a per-byte "has been written" flag.
  function automatic exp_t model(bit wr, logic [AW-1:0] a, logic [31:0] d, logic [3:0] s);
    exp_t e;
    int idx;
    idx       = int'(a) / 4;
    e.is_read = !wr;
    e.addr    = a;
    e.data    = 32'h0;
    e.mask    = 32'hFFFF_FFFF;
    e.err     = 1'b0;
    if (idx >= DEPTH) begin
      e.err = 1'b1;
    end else if (wr) begin
`ifdef APB_RAM_RO_REGION_EN
      if (idx >= RO_BASE) begin
        e.err = 1'b1;
        return e;
      end
`endif
      for (int b = 0; b < 4; b++) begin
        if (s[b]) begin
          ref_mem[idx][8*b +: 8] = d[8*b +: 8];
          ref_known[idx][b]      = 1'b1;
        end
      end
    end else begin
      e.data = ref_mem[idx];
      e.mask = 32'h0;
      for (int b = 0; b < 4; b++) begin
        if (ref_known[idx][b]) e.mask[8*b +: 8] = 8'hFF;
      end
    end
    return e;
  endfunction

  // Monitor: counts access-phase cycles and checks each completed transfer.
  always @(negedge pclk) begin
    if (!presetn && psel && penable) acc_cnt++;
    else acc_cnt = 0;

    if (pslverr === 1'b1 && pready !== 1'b1) begin
      n_vec++; n_bad++;
      $display("FAIL pslverr_without_pready: pslverr=%b pready=%b required pslverr=0", pslverr, pready);
    end

    if (pready === 1'b1) begin
      if (exp_q.size() == 0) begin
        n_vec++; n_bad++;
        $display("FAIL unexpected_pready: pready=1 required 0 (no transfer pending)");
      end else begin
        mon_e = exp_q.pop_front();
        $display("%s addr=%h prdata=%h pslverr=%b lat=%0d", mon_e.is_read ? "RD" : "WR",
                 mon_e.addr, prdata, pslverr, acc_cnt);
        n_vec++;
        if (acc_cnt != LAT) begin
          n_bad++;
          $display("FAIL latency addr=%h: got %0d access cycles, required %0d", mon_e.addr, acc_cnt, LAT);
        end
        n_vec++;
        if (pslverr !== mon_e.err) begin
          n_bad++;
          $display("FAIL pslverr addr=%h: got %b, required %b", mon_e.addr, pslverr, mon_e.err);
        end
        if (mon_e.is_read) begin
          n_vec++;
          if ((prdata & mon_e.mask) !== (mon_e.data & mon_e.mask)) begin
            n_bad++;
            $display("FAIL prdata addr=%h: got %h, required %h (mask %h)", mon_e.addr, prdata,
                     mon_e.data, mon_e.mask);
          end
        end
      end
    end
  end

  task automatic check_quiet(input string tag);
    n_vec++;
    if (pready !== 1'b0) begin n_bad++; $display("FAIL %s_pready: got %b, required 0", tag, pready); end
    n_vec++;
    if (pslverr !== 1'b0) begin n_bad++; $display("FAIL %s_pslverr: got %b, required 0", tag, pslverr); end
    n_vec++;
    if (prdata !== 32'h0) begin n_bad++; $display("FAIL %s_prdata: got %h, required 0", tag, prdata); end
  endtask

  // Complete transfer; called at posedge+1, returns at posedge+1 with the bus idle.
  task automatic xfer(input bit wr, input logic [AW-1:0] a, input logic [31:0] d, input logic [3:0] s);
    int n;
    exp_q.push_back(model(wr, a, d, s));
    psel = 1'b1; penable = 1'b0; pwrite = wr; paddr = a; pwdata = d; pstrb = s;
    @(posedge pclk); #1;
    penable = 1'b1;
    n = 0;
    @(negedge pclk);
    while (pready !== 1'b1 && n < 40) begin
      @(negedge pclk);
      n++;
    end
    if (pready !== 1'b1) begin
      n_vec++; n_bad++;
      $display("FAIL timeout addr=%h: pready=%b after %0d cycles, required 1", a, pready, n);
      void'(exp_q.pop_back());
    end
    @(posedge pclk); #1;
    psel = 1'b0; penable = 1'b0;
  endtask

  // Write that the master abandons after n_acc access cycles (before commit).
  task automatic abort_write(input logic [AW-1:0] a, input logic [31:0] d, input int n_acc);
    psel = 1'b1; penable = 1'b0; pwrite = 1'b1; paddr = a; pwdata = d; pstrb = 4'hF;
    for (int k = 0; k < n_acc; k++) begin
      @(posedge pclk); #1;
      penable = 1'b1;
    end
    @(posedge pclk); #1;
    psel = 1'b0; penable = 1'b0;
    @(posedge pclk); #1;
  endtask

  // Write interrupted by a one-cycle reset during its wait states.
  task automatic reset_mid_write(input logic [AW-1:0] a, input logic [31:0] d);
    psel = 1'b1; penable = 1'b0; pwrite = 1'b1; paddr = a; pwdata = d; pstrb = 4'hF;
    @(posedge pclk); #1;
    penable = 1'b1;
    @(posedge pclk); #1;
    psel = 1'b0; penable = 1'b0; presetn = 1'b1;
    @(posedge pclk); #1;
    presetn = 1'b0;
    check_quiet("after_mid_reset");
  endtask

  initial begin
    logic [AW-1:0] ra;
    presetn = 1'b1; psel = 1'b0; penable = 1'b0; pwrite = 1'b0;
    paddr = '0; pwdata = '0; pstrb = '0;

    for (int i = 0; i < 3; i++) begin
      @(posedge pclk); #1;
      check_quiet("reset");
    end
    presetn = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(posedge pclk); #1;
      check_quiet("idle");
    end

    // Full write / read, then strobed overwrite.
    xfer(1'b1, 9'h010, 32'hDEAD_BEEF, 4'hF);
    xfer(1'b0, 9'h010, 32'h0, 4'h0);
    xfer(1'b1, 9'h010, 32'h1122_3344, 4'h5);
    xfer(1'b0, 9'h010, 32'h0, 4'hF);
    // pstrb=0 is a no-op write; misaligned read hits the same word.
    xfer(1'b1, 9'h012, 32'hFFFF_FFFF, 4'h0);
    xfer(1'b0, 9'h013, 32'h0, 4'h0);

    // Range boundary: last legal word and first illegal word.
    xfer(1'b1, 9'h0FC, 32'hCAFE_F00D, 4'hF);
    xfer(1'b0, 9'h0FC, 32'h0, 4'h0);
    xfer(1'b1, 9'h100, 32'h1234_5678, 4'hF);
    xfer(1'b0, 9'h100, 32'h0, 4'h0);
    xfer(1'b0, 9'h1FF, 32'h0, 4'h0);

    // Give every word a defined value.
    for (int i = 0; i < DEPTH; i++) begin
      ra = AW'(i * 4);
      xfer(1'b1, ra, $urandom, 4'hF);
    end

    // Protocol abort in the 2nd access cycle leaves mem[8] intact.
    abort_write(9'h020, 32'h5A5A_5A5A, 1);
    xfer(1'b0, 9'h020, 32'h0, 4'h0);

    // Reset during wait states drops the write.
    reset_mid_write(9'h024, 32'h0BAD_0BAD);
    xfer(1'b0, 9'h024, 32'h0, 4'h0);

`ifdef APB_RAM_RO_REGION_EN
    xfer(1'b1, 9'h0C0, 32'hA5A5_A5A5, 4'hF);
    xfer(1'b0, 9'h0C0, 32'h0, 4'h0);
    xfer(1'b1, 9'h0BC, 32'h7777_1111, 4'hF);
    xfer(1'b0, 9'h0BC, 32'h0, 4'h0);
`endif

    // Randomized mix of reads, strobed writes, out-of-range and aborts.
    for (int i = 0; i < 160; i++) begin
      ra = AW'($urandom_range(0, (1 << AW) - 1));
      if ($urandom_range(0, 9) == 0) begin
        abort_write(ra, $urandom, int'($urandom_range(0, WAITC)));
      end else begin
        xfer(1'($urandom_range(0, 1)), ra, $urandom, 4'($urandom_range(0, 15)));
      end
    end

    repeat (5) @(posedge pclk);
    n_vec++;
    if (exp_q.size() != 0) begin
      n_bad++;
      $display("FAIL scoreboard_drain: %0d responses outstanding, required 0", exp_q.size());
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule

// File: doc/apb_ram_strb.md
Name: apb_ram_strb

Overview:
- Parametrised APB4 slave RAM; next generation of the team's APB RAM model.
- Adds generic data width and depth, byte-lane write strobes, a programmable wait-state counter, out-of-range error response, and clean protocol-abort handling.
- Sits behind the APB interconnect as the memory target for the APB testbench environment and for SoC scratch RAM.

Parameters:
- ADDR_WIDTH, 8, APB byte-address width.
- DATA_WIDTH, 32, data bus width; a multiple of 8, minimum 8.
- RAM_DEPTH, 64, number of DATA_WIDTH-bit words.
- WAIT_CYCLES, 0, extra access-phase cycles before pready; range 0..15.
- RO_BASE, 48, first read-only word index; used only with APB_RAM_RO_REGION_EN.

Ports:
- pclk  in  1  clock; all logic is rising-edge.
- presetn  in  1  reset; synchronous, active-high (1 = reset) despite the name.
- psel  in  1  slave select.
- penable  in  1  access-phase qualifier.
- pwrite  in  1  1 = write, 0 = read.
- paddr  in  ADDR_WIDTH  byte address.
- pwdata  in  DATA_WIDTH  write data.
- pstrb  in  DATA_WIDTH/8  byte write strobes.
- prdata  out  DATA_WIDTH  read data.
- pready  out  1  transfer-complete.
- pslverr  out  1  error response; valid only while pready=1.

Behaviour:
- Reset (presetn=1 at a pclk edge):
  - state=IDLE, pready=0, pslverr=0, prdata=0, wait counter=0.
  - Memory contents are not cleared; they are X until first written.
- Word index: idx = paddr >> log2(DATA_WIDTH/8). Low address bits are ignored, so misaligned accesses are not an error.
- FSM states: IDLE, ACCESS, RESP.
- IDLE:
  - psel=1 and penable=0 (setup phase): capture paddr, pwrite, pwdata, pstrb; load cnt=WAIT_CYCLES; go to ACCESS.
  - Otherwise stay in IDLE.
- ACCESS:
  - psel=0 or penable=0 (protocol abort): go to IDLE. No memory update, pready stays 0.
  - cnt!=0: decrement cnt; stay in ACCESS.
  - cnt==0: commit the transfer, register pready=1 for the next cycle, go to RESP.
- Commit rules:
  - idx >= RAM_DEPTH: pslverr=1, no write, prdata=0.
  - Write: for each byte b with pstrb[b]=1, mem[idx][8b+7:8b] = captured pwdata byte. Bytes with strobe 0 are unchanged. pstrb=0 is a legal no-op write with pslverr=0.
  - Read: prdata=mem[idx] (pstrb ignored); pslverr=0.
- RESP:
  - pready=1 for exactly one cycle; the master samples here.
  - Next cycle: pready=0, pslverr=0, go to IDLE.
  - prdata holds its value until the next read commit.
- Latency: pready is high in the (WAIT_CYCLES+2)-th access-phase cycle, counting from the first cycle with penable=1. This gives one inherent wait state plus WAIT_CYCLES.
- Back-to-back transfers: a new setup phase in the cycle after RESP is accepted normally from IDLE.
- Reset mid-transfer:
  - Takes priority over everything; the FSM returns to IDLE.
  - A write not yet committed is dropped.
  - A write committed in the same edge as reset is also dropped (reset wins).
- pready and pslverr are never both driven high outside RESP.
- The slave ignores psel while in RESP.

Optional Feature:
- Macro: APB_RAM_RO_REGION_EN.
- Defined:
  - Words with RO_BASE <= idx < RAM_DEPTH are read-only.
  - A write to this range completes with pready=1, pslverr=1, memory unchanged.
  - Reads of this range behave normally.
  - The RO_BASE parameter is checked at elaboration to satisfy RO_BASE <= RAM_DEPTH.
- Not defined: RO_BASE is ignored and all in-range words are writable.

Test Plan:
- Reset hold for 3 cycles, then idle bus: pready=0, pslverr=0, prdata=0 throughout.
- Full write then read, defaults:
  - Write paddr=0x10, pwdata=0xDEADBEEF, pstrb=0xF.
  - Read paddr=0x10: prdata=0xDEADBEEF, pslverr=0.
  - pready is high in the 2nd access cycle of each transfer.
- Strobes:
  - After the write above, write paddr=0x10, pwdata=0x11223344, pstrb=0x5.
  - Read paddr=0x10: prdata=0xDE22BE44.
- Out of range: write then read paddr=0xFC (idx 63 is legal) and paddr=0x100 with ADDR_WIDTH=9 (idx 64).
  - idx 64: pslverr=1 and prdata=0.
  - idx 63: data round-trips.
- Wait states, WAIT_CYCLES=3:
  - pready asserts in the 5th access cycle.
  - Dropping psel in the 2nd access cycle of a write to 0x20 leaves mem[8] unchanged on readback.
- APB_RAM_RO_REGION_EN defined:
  - Write 0xA5A5A5A5 to paddr=0xC0 (idx 48): pslverr=1.
  - Readback returns the prior value.
  - A write to 0xBC (idx 47) succeeds.
